uart_tx_feeder: RTL
===================

// Module: uart_tx_feeder
// PURPOSE
//  Byte buffer and launch controller directly upstream of the duplex UART transmitter.
//  Accepts bytes from the host over a valid/ready interface and stores them in a FIFO.
//  Drives the transmitter's send/data_in pins one frame at a time.
//  Paces each launch on the transmitter's active/done flags, so the host never
//  tracks frame timing.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  DATA_W  8   byte width; must equal the transmitter data_in width
// PORTS
//  clock           in   1                system clock, shared with the UART
//  reset           in   1                asynchronous, active-high reset
//  wr_valid        in   1                host offers wr_data
//  wr_data         in   DATA_W           byte to queue
//  wr_ready        out  1                FIFO can accept; equals !full
//  tx_active_flag  in   1                transmitter frame in progress
//  tx_done_flag    in   1                transmitter frame complete
//  send            out  1                launch request to the transmitter
//  data_in         out  DATA_W           byte presented to the transmitter
//  level           out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  empty           out  1                level == 0
//  busy            out  1                FSM not in IDLE
// BEHAVIOUR
//  Reset: FIFO cleared, level=0, empty=1, wr_ready=1, send=0, data_in=0, busy=0, FSM=IDLE.
//   Reset may assert at any time; an in-flight byte is discarded, and send drops
//   asynchronously.
//  Push: a byte is written on the rising edge when wr_valid && wr_ready.
//   With wr_valid=1 and full=1, nothing is written and no error is raised; the host must hold.
//   No bypass: a pop and a push in the same cycle while full does not admit the push.
//  Pop: occurs only on the IDLE->LAUNCH transition; head byte registered into data_in.
//   Same-cycle push and pop when not full: level unchanged, both take effect.
//  Pointers: log2(DEPTH)-bit read/write pointers, wrap modulo DEPTH.
//   level is kept as a separate counter (+1 push, -1 pop, 0 both).
//  FSM (registered outputs):
//   IDLE: send=0; if !empty && !tx_active_flag -> LAUNCH (pop, latch data_in).
//   LAUNCH: send=1; data_in held; when tx_active_flag=1 -> WAIT_DONE.
//    If tx_done_flag=1 arrives while still in LAUNCH, the frame finished -> IDLE.
//   WAIT_DONE: send=0; data_in held; when tx_done_flag=1 -> IDLE.
//  Latency: empty FIFO, push at edge N -> empty=0 after N -> LAUNCH, send=1 after N+1.
//  Back-to-back: after done, IDLE takes one cycle, giving at least one send=0 cycle
//   between frames.
//  tx_done_flag or tx_active_flag outside the states listed above is ignored.
//  busy = (state != IDLE); data_in keeps its last value in IDLE.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} feeder_state_t;
//   localparam UART_DATA_W = 8.
//  Sub-module sync_fifo (DEPTH, DATA_W): push/pop/level/full/empty, with no
//   show-ahead beyond the rd_data head.
//  Top level: sync_fifo instance, 2-bit FSM, and the data_in/send output registers.
// TESTING
//  1 Reset mid-WAIT_DONE with 3 bytes queued -> send=0, data_in=0, level=0,
//    empty=1, busy=0 on the same edge.
//  2 Push 0xA5 into an idle, empty FIFO -> send=1 two cycles later, data_in=0xA5.
//    Active pulse -> send=0. Done -> busy=0.
//  3 Push 16 bytes 0x00..0x0F with the transmitter held active -> after the 16th,
//    wr_ready=0 and level=16; a 17th push (0xFF) is not stored.
//    Drain -> bytes appear in order 0x00..0x0F, and 0xFF never appears.
//  4 Push and pop in the same cycle at level=5 -> level stays 5; the popped byte
//    is the oldest.
//  5 Done asserted while in LAUNCH (no active seen) -> FSM goes to IDLE;
//    the next byte launches one cycle later.
//  6 Spurious tx_done_flag in IDLE with an empty FIFO -> no state change,
//    send stays 0.
//  Also check with a scoreboard: every accepted byte is launched exactly once,
//   in order, across 1000 random push/active/done cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART transmit path.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with occupancy counter; rd_data is the head entry.
// Rev     : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int                     c_ADDR_W     = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]      c_FULL_LEVEL = (c_ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;
    logic                w_push;
    logic                w_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push  = push && (r_level != c_FULL_LEVEL);
    assign w_pop   = pop && (r_level != '0);

    assign full    = (r_level == c_FULL_LEVEL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_feeder
// Brief   : Byte FIFO plus launch FSM pacing frames into the UART transmitter.
// Rev     : 1.0
// ============================================================================
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       tx_active_flag,
    input  logic                       tx_done_flag,
    output logic                       send,
    output logic [DATA_W-1:0]          data_in,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       busy
);

    feeder_state_t     r_state;
    logic              r_send;
    logic [DATA_W-1:0] r_data_in;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    // The pop and the IDLE->LAUNCH transition are the same event.
    assign w_pop = (r_state == IDLE) && !w_empty && !tx_active_flag;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_valid),
        .wr_data (wr_data),
        .pop     (w_pop),
        .rd_data (w_head),
        .level   (level),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_send    <= 1'b0;
            r_data_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state   <= LAUNCH;
                        r_send    <= 1'b1;
                        r_data_in <= w_head;
                    end
                end
                LAUNCH: begin
                    // A done seen before any active means the frame already ended.
                    if (tx_done_flag) begin
                        r_state <= IDLE;
                        r_send  <= 1'b0;
                    end else if (tx_active_flag) begin
                        r_state <= WAIT_DONE;
                        r_send  <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_flag) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_send  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready = !w_full;
    assign empty    = w_empty;
    assign send     = r_send;
    assign data_in  = r_data_in;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire
